mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single-port data block memory between the instruction-fetch requester and the executer's load/store requester. It issues at most one access per cycle. It routes the one-cycle-latency read data back to whichever requester issued the read. Loads and stores get priority, bounded by a starvation counter that guarantees fetch forward progress. It sits between the fetch stage, the executer and the block memory instance, and replaces the executer's direct memory hookup.

## Interface
- ADDR_W, 5: memory word-address width
- DATA_W, 32: data width
- STARVE_MAX, 3: max consecutive cycles a pending fetch may lose arbitration before it is forced to win (≥1)

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- IF_REQ  in  1  fetch read request; held with IF_ADDR stable until IF_GNT
- IF_ADDR  in  ADDR_W  fetch address
- IF_FLUSH  in  1  branch/jump redirect: kill fetch grant this cycle and any fetch read in flight
- IF_GNT  out  1  fetch request accepted this cycle (combinational)
- IF_RVALID  out  1  fetch read data valid
- IF_RDATA  out  DATA_W  fetch read data
- D_REQ  in  1  load/store request; D_WE/D_ADDR/D_WDATA held stable until D_GNT
- D_WE  in  1  1 = store, 0 = load
- D_ADDR  in  ADDR_W  data address
- D_WDATA  in  DATA_W  store data
- D_GNT  out  1  data request accepted this cycle (combinational)
- D_RVALID  out  1  load data valid
- D_RDATA  out  DATA_W  load data
- MEM_ADDR  out  ADDR_W  to block memory
- MEM_WE  out  1  to block memory
- MEM_WDATA  out  DATA_W  to block memory
- MEM_RDATA  in  DATA_W  from block memory; valid the cycle after the address is presented

## Operation
- **Arbitration each cycle (combinational):**
  - If RST = 1: no grant.
  - Else if the starvation counter equals STARVE_MAX and IF_REQ = 1 and IF_FLUSH = 0: fetch wins.
  - Else if D_REQ = 1: data wins.
  - Else if IF_REQ = 1 and IF_FLUSH = 0: fetch wins.
  - Else: idle.
- Exactly one of IF_GNT and D_GNT is high, or neither.
- **Memory drive:**
  - Fetch wins: MEM_ADDR = IF_ADDR, MEM_WE = 0.
  - Data wins: MEM_ADDR = D_ADDR, MEM_WE = D_WE, MEM_WDATA = D_WDATA.
  - Idle: MEM_ADDR = 0, MEM_WE = 0, MEM_WDATA = 0.
- **Starvation counter** (width $clog2(STARVE_MAX+1), saturating):
  - Increments when IF_REQ = 1, IF_FLUSH = 0, and fetch is not granted.
  - Clears when IF_GNT = 1, IF_REQ = 0, or IF_FLUSH = 1.
- **Pending-read tracking** (registers if_pend, d_pend):
  - if_pend <= IF_GNT & ~IF_FLUSH.
  - d_pend <= D_GNT & ~D_WE.
  - Stores never produce RVALID.
- **Outputs:**
  - IF_RVALID = if_pend & ~IF_FLUSH. A flush in the return cycle also kills the data.
  - D_RVALID = d_pend.
  - IF_RDATA = MEM_RDATA when IF_RVALID, else 0.
  - D_RDATA = MEM_RDATA when D_RVALID, else 0.
- **Back-to-back:** a new grant is allowed in the same cycle a previous read returns. Throughput is 1 access/cycle.
- **Requester obligations:** requests are not withdrawn before grant, except fetch on IF_FLUSH. The arbiter does not check this.

## Timing
- **Reset:** RST high at a posedge clears if_pend, d_pend and the counter. While RST = 1, the following are held 0:
  - IF_GNT, D_GNT, MEM_WE, MEM_ADDR, MEM_WDATA
  - IF_RVALID, D_RVALID, IF_RDATA, D_RDATA
- **Grant:** same cycle as the winning request (zero-latency).
- **Read latency:** grant in cycle N gives RVALID and RDATA in cycle N+1.
- **Store:** written at the posedge ending the grant cycle. A load to the same address granted in N+1 returns the new data in N+2.
- **Reset mid-operation:** a read granted in cycle N with RST high in N+1 produces no RVALID in N+1.
- **Starvation, STARVE_MAX = 3:**
  - With D_REQ and IF_REQ both held, data is granted on cycles 0, 1, 2 and fetch on cycle 3.
  - The pattern then repeats, so fetch receives ≥1 grant per STARVE_MAX+1 cycles.
- **Simultaneous events:**
  - IF_FLUSH with a forced fetch: data may win instead, and the counter clears.
  - RST with any request: reset wins.

## Test plan
- **Reset:** hold RST 3 cycles with IF_REQ = D_REQ = 1 → all outputs 0. Release → D_GNT = 1 the first cycle, D_RVALID the next.
- **Store-to-load:** D store addr 5 data 0xDEADBEEF in cycle 1, D load addr 5 in cycle 2 → D_RVALID = 1, D_RDATA = 0xDEADBEEF in cycle 3. IF_RVALID stays 0 throughout.
- **Fetch only:** IF_REQ with addresses 0,1,2,3 over 4 cycles, memory preloaded with word i = i+0x100 → IF_GNT every cycle, IF_RDATA = 0x100..0x103 in cycles 2..5.
- **Starvation, STARVE_MAX = 3:** D_REQ and IF_REQ held 8 cycles → grant sequence D,D,D,IF,D,D,D,IF.
- **Flush:** fetch granted addr 7 in cycle N, IF_FLUSH = 1 in N+1 → IF_RVALID = 0 in N+1. A fetch request in N+1 is not granted, and a data request in N+1 is granted.
- **Mid-flight reset:** load granted in cycle N, RST = 1 in N+1 → D_RVALID = 0 in N+1 and N+2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data block memory between instruction fetch and load/store.
// Data has priority; a saturating starvation counter forces a fetch win after STARVE_MAX losses.
module mem_port_arbiter #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IF_REQ,
   input  logic [ADDR_W-1:0] IF_ADDR,
   input  logic              IF_FLUSH,
   output logic              IF_GNT,
   output logic              IF_RVALID,
   output logic [DATA_W-1:0] IF_RDATA,
   input  logic              D_REQ,
   input  logic              D_WE,
   input  logic [ADDR_W-1:0] D_ADDR,
   input  logic [DATA_W-1:0] D_WDATA,
   output logic              D_GNT,
   output logic              D_RVALID,
   output logic [DATA_W-1:0] D_RDATA,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic              MEM_WE,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA
);

   localparam int            CW   = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

   logic [CW-1:0] starve_cnt;
   logic          if_pend, d_pend;
   logic          if_live, force_if;

   // A flushed fetch is treated as absent: it neither wins nor accrues starvation.
   assign if_live  = IF_REQ & ~IF_FLUSH;
   assign force_if = if_live & (starve_cnt == CMAX);

   always_comb begin
      IF_GNT = ~RST & (force_if | (if_live & ~D_REQ));
      D_GNT  = ~RST & D_REQ & ~force_if;
   end

   always_comb begin
      MEM_ADDR  = '0;
      MEM_WE    = 1'b0;
      MEM_WDATA = '0;
      if (IF_GNT) begin
         MEM_ADDR = IF_ADDR;
      end else if (D_GNT) begin
         MEM_ADDR  = D_ADDR;
         MEM_WE    = D_WE;
         MEM_WDATA = D_WDATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         if_pend    <= 1'b0;
         d_pend     <= 1'b0;
         starve_cnt <= '0;
      end else begin
         if_pend <= IF_GNT & ~IF_FLUSH;
         d_pend  <= D_GNT & ~D_WE;
         if (IF_GNT || !IF_REQ || IF_FLUSH)
            starve_cnt <= '0;
         else if (starve_cnt != CMAX)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Return path is masked by reset so a read in flight when reset hits never surfaces.
   always_comb begin
      IF_RVALID = ~RST & if_pend & ~IF_FLUSH;
      D_RVALID  = ~RST & d_pend;
      IF_RDATA  = IF_RVALID ? MEM_RDATA : '0;
      D_RDATA   = D_RVALID  ? MEM_RDATA : '0;
   end

endmodule
